// File: rtl/costas_ctrl_pkg.sv
// Shared types and constants for the costas demodulator frame controller.
package costas_ctrl_pkg;

  localparam int ADC_W  = 10;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_RECEIVE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // One FIFO entry: frame-end marker above the data byte.
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_ent_t;

  // CRC-8, MSB first, one byte per call.
  function automatic logic [BYTE_W-1:0] crc8_byte(input logic [BYTE_W-1:0] crc,
                                                  input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] c;
    c = crc ^ b;
    for (int i = 0; i < BYTE_W; i++)
      c = c[BYTE_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/costas_frame_ctrl_if.sv
// Sample, byte and host-stream signals of the frame controller.
// master = controller side, slave = demodulator/front-end/host side.
interface costas_frame_ctrl_if;
  import costas_ctrl_pkg::*;

  logic              adcValid;
  logic [ADC_W-1:0]  adcData;
  logic              pushADC;
  logic [ADC_W-1:0]  ADC;
  logic              pushByte;
  logic [BYTE_W-1:0] Byte;
  logic              Sync;
  logic              lastByte;
  logic              stopIn;
  logic              outValid;
  logic [BYTE_W-1:0] outData;
  logic              outLast;
  logic              outReady;

  modport master (
    input  adcValid, adcData, pushByte, Byte, Sync, lastByte, outReady,
    output pushADC, ADC, stopIn, outValid, outData, outLast
  );

  modport slave (
    output adcValid, adcData, pushByte, Byte, Sync, lastByte, outReady,
    input  pushADC, ADC, stopIn, outValid, outData, outLast
  );

endinterface

// File: rtl/costas_byte_fifo.sv
// Synchronous byte+last FIFO; a write at full lands if a read happens that cycle.
module costas_byte_fifo
  import costas_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr,
  input  fifo_ent_t wdata,
  input  logic      rd,
  output fifo_ent_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  fifo_ent_t     mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);
  assign rdata = mem[rptr];

  always_ff @(posedge clk)
    if (wr_en) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/costas_frame_ctrl.sv
// Acquisition/reception sequencer around the costas BPSK demodulator.
// Optional CRC-8 frame check: define COSTAS_FRAME_CRC_EN.
module costas_frame_ctrl
  import costas_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACQ_TIMEOUT = 65536,
  parameter int MAX_FRAME   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  costas_frame_ctrl_if.master bus,
  output logic [1:0]  state,
  output logic        frameErr,
  output logic        acqTimeout,
  output logic        crcErr,
  output logic [15:0] frameCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACQ_TIMEOUT + 1);

  state_t            st, st_n;
  logic [TW-1:0]     tmo_cnt;
  logic [7:0]        byte_cnt;
  logic              vld_q;
  logic [ADC_W-1:0]  adc_q;
  logic              stop_q;

  logic              active, push_byte, end_frame, max_hit, sync_lost, drop;
  logic              start_acq, set_ferr, set_tmo, frame_done;
  logic              fifo_rd, fifo_full, fifo_empty;
  fifo_ent_t         fifo_head;
  logic [CW-1:0]     fifo_cnt, cnt_n;

  assign active    = (st == ST_ACQUIRE) || (st == ST_RECEIVE);
  assign push_byte = bus.pushByte && (st == ST_RECEIVE);
  assign end_frame = push_byte && bus.lastByte;
  assign max_hit   = push_byte && !bus.lastByte && (byte_cnt == 8'(MAX_FRAME - 1));
  assign sync_lost = !bus.Sync && !end_frame;
  assign fifo_rd   = bus.outValid && bus.outReady;
  assign drop      = push_byte && fifo_full && !fifo_rd;

  costas_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push_byte),
    .wdata ({bus.lastByte, bus.Byte}),
    .rd    (fifo_rd),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    st_n       = st;
    start_acq  = 1'b0;
    set_ferr   = 1'b0;
    set_tmo    = 1'b0;
    frame_done = 1'b0;
    case (st)
      ST_IDLE:
        if (enable) begin
          st_n      = ST_ACQUIRE;
          start_acq = 1'b1;
        end
      ST_ACQUIRE:
        if (!enable) st_n = ST_IDLE;
        else if (bus.Sync) st_n = ST_RECEIVE;
        else if (tmo_cnt == TW'(ACQ_TIMEOUT - 1)) begin
          st_n    = ST_IDLE;
          set_tmo = 1'b1;
        end
      ST_RECEIVE: begin
        if (drop) set_ferr = 1'b1;
        if (end_frame) st_n = ST_DRAIN;
        else if (max_hit || sync_lost) begin
          st_n     = ST_DRAIN;
          set_ferr = 1'b1;
        end
      end
      ST_DRAIN:
        if (fifo_empty) begin
          frame_done = 1'b1;
          if (enable) begin
            st_n      = ST_ACQUIRE;
            start_acq = 1'b1;
          end else begin
            st_n = ST_IDLE;
          end
        end
      default: st_n = ST_IDLE;
    endcase
  end

  // stopIn looks at next-cycle occupancy so its register lag is covered by the margin.
  assign cnt_n = fifo_cnt + CW'(push_byte && !drop) - CW'(fifo_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      tmo_cnt    <= '0;
      byte_cnt   <= '0;
      frameErr   <= 1'b0;
      acqTimeout <= 1'b0;
      frameCount <= '0;
      stop_q     <= 1'b1;
      vld_q      <= 1'b0;
      adc_q      <= '0;
    end else begin
      st     <= st_n;
      vld_q  <= bus.adcValid && active;
      adc_q  <= bus.adcData;
      stop_q <= !((st_n == ST_ACQUIRE) || (st_n == ST_RECEIVE)) ||
                (CW'(FIFO_DEPTH) - cnt_n <= CW'(2));
      if (start_acq) begin
        tmo_cnt    <= '0;
        byte_cnt   <= '0;
        frameErr   <= 1'b0;
        acqTimeout <= 1'b0;
      end else begin
        if (st == ST_ACQUIRE) tmo_cnt <= tmo_cnt + TW'(1);
        if (push_byte && byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
        if (set_ferr) frameErr <= 1'b1;
        if (set_tmo) acqTimeout <= 1'b1;
      end
      if (frame_done) frameCount <= frameCount + 16'd1;
    end
  end

`ifdef COSTAS_FRAME_CRC_EN
  logic [7:0] crc, crc_n;

  assign crc_n = (push_byte && !drop) ? crc8_byte(crc, bus.Byte) : crc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc    <= '0;
      crcErr <= 1'b0;
    end else if (start_acq) begin
      crc    <= '0;
      crcErr <= 1'b0;
    end else begin
      crc <= crc_n;
      if (st == ST_RECEIVE && st_n == ST_DRAIN) crcErr <= (crc_n != 8'h00);
    end
  end
`else
  assign crcErr = 1'b0;
`endif

  assign state       = st;
  assign bus.pushADC = vld_q;
  assign bus.ADC     = adc_q;
  assign bus.stopIn  = stop_q;
  assign bus.outValid = !fifo_empty;
  assign bus.outData  = fifo_head.data;
  // An errored frame gets terminated on whatever byte is left last.
  assign bus.outLast  = fifo_head.last ||
                        ((st == ST_DRAIN) && frameErr && (fifo_cnt == CW'(1)));

endmodule

// File: tb/tb_costas_frame_ctrl.sv
// Scoreboard bench for costas_frame_ctrl: expected host beats queued at byte push.
module tb_costas_frame_ctrl;
  import costas_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 128;
  localparam int MAXF  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  state;
  logic        frameErr, acqTimeout, crcErr;
  logic [15:0] frameCount;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  logic [8:0] beat_exp;

  costas_frame_ctrl_if bus();

  costas_frame_ctrl #(.FIFO_DEPTH(DEPTH), .ACQ_TIMEOUT(TMO), .MAX_FRAME(MAXF)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .state      (state),
    .frameErr   (frameErr),
    .acqTimeout (acqTimeout),
    .crcErr     (crcErr),
    .frameCount (frameCount)
  );

  always #5 clk = ~clk;

  // Host beats transfer on the next rising edge; checked here, mid-cycle.
  always @(negedge clk) begin
    if (reset && bus.outValid && bus.outReady) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL host_beat: got %h, required no beat", {bus.outLast, bus.outData});
      end else begin
        beat_exp = sb.pop_front();
        if ({bus.outLast, bus.outData} !== beat_exp) begin
          errors++;
          $display("FAIL host_beat: got last/data %h, required %h", {bus.outLast, bus.outData}, beat_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    enable = 0; bus.adcValid = 0; bus.adcData = '0; bus.pushByte = 0; bus.Byte = '0;
    bus.Sync = 0; bus.lastByte = 0; bus.outReady = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 0; sb.delete(); tick(); tick(); reset = 1; tick();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state === s) break;
      tick();
    end
  endtask

  task automatic push(input logic [7:0] b, input logic lin, input logic lexp);
    bus.pushByte = 1; bus.Byte = b; bus.lastByte = lin;
    sb.push_back({lexp, b});
    tick();
    bus.pushByte = 0; bus.lastByte = 0;
  endtask

  task automatic enter_receive();
    enable = 1; tick(); bus.Sync = 1; tick();
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 0; tick(); tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++; if ({bus.stopIn, bus.outValid, bus.pushADC, bus.outLast} !== 4'b1000) begin errors++; $display("FAIL reset_outs: got stop/valid/pushADC/last %b, required 1000", {bus.stopIn, bus.outValid, bus.pushADC, bus.outLast}); end
    checks++; if ({frameErr, acqTimeout, crcErr, frameCount} !== 19'd0) begin errors++; $display("FAIL reset_flags: got %h, required 0", {frameErr, acqTimeout, crcErr, frameCount}); end
    reset = 1; tick();
  endtask

  task automatic test_adc_forward();
    do_reset();
    enable = 1; bus.adcValid = 1; bus.adcData = 10'h2A5; tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL adc_enter_acq: got %0d, required 1", state); end
    checks++; if (bus.pushADC !== 1'b0) begin errors++; $display("FAIL adc_idle_gate: got %b, required 0", bus.pushADC); end
    checks++; if (bus.stopIn !== 1'b0) begin errors++; $display("FAIL adc_acq_stop: got %b, required 0", bus.stopIn); end
    bus.adcData = 10'h15A; tick();
    checks++; if ({bus.pushADC, bus.ADC} !== {1'b1, 10'h15A}) begin errors++; $display("FAIL adc_forward: got %b/%h, required 1/15a", bus.pushADC, bus.ADC); end
    bus.adcValid = 0; enable = 0; tick();
    checks++; if ({state, bus.pushADC} !== 3'b000) begin errors++; $display("FAIL adc_enable_drop: got state %0d push %b, required 0 0", state, bus.pushADC); end
  endtask

  task automatic test_lock_frame();
    do_reset();
    bus.outReady = 1; enable = 1; tick();
    repeat (99) tick();
    bus.Sync = 1; tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock_receive: got %0d, required 2", state); end
    push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 1, 1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL lock_drain: got %0d, required 3", state); end
    enable = 0; bus.Sync = 0;
    wait_state(2'd0, 20);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL lock_idle: got %0d, required 0", state); end
    checks++; if ({frameErr, frameCount} !== {1'b0, 16'd1}) begin errors++; $display("FAIL lock_count: got err %b count %0d, required 0 1", frameErr, frameCount); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL lock_beats: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1; tick();
    repeat (TMO - 1) tick();
    checks++; if ({state, acqTimeout} !== 3'b010) begin errors++; $display("FAIL tmo_last_cycle: got state %0d tmo %b, required 1 0", state, acqTimeout); end
    tick();
    checks++; if ({state, acqTimeout} !== 3'b001) begin errors++; $display("FAIL tmo_fire: got state %0d tmo %b, required 0 1", state, acqTimeout); end
    enable = 0; tick();
    checks++; if ({state, acqTimeout} !== 3'b001) begin errors++; $display("FAIL tmo_sticky: got state %0d tmo %b, required 0 1", state, acqTimeout); end
  endtask

  task automatic test_backpressure();
    int n, rise_at;
    logic prev_stop;
    do_reset();
    enter_receive();
    checks++; if ({state, bus.stopIn} !== 3'b100) begin errors++; $display("FAIL bp_start: got state %0d stop %b, required 2 0", state, bus.stopIn); end
    n = 0; rise_at = -1; prev_stop = 0;
    // Source reacts to stopIn one cycle late, like an in-flight byte.
    for (int c = 0; c < 8; c++) begin
      if (bus.stopIn && rise_at < 0) rise_at = n;
      if (!prev_stop) begin
        bus.pushByte = 1; bus.Byte = 8'h40 + 8'(n); sb.push_back({1'b0, 8'h40 + 8'(n)}); n++;
      end else bus.pushByte = 0;
      prev_stop = bus.stopIn;
      tick();
    end
    bus.pushByte = 0;
    checks++; if (rise_at != 2) begin errors++; $display("FAIL bp_rise: got stop after %0d bytes, required 2", rise_at); end
    checks++; if (n != 3) begin errors++; $display("FAIL bp_pushed: got %0d bytes, required 3", n); end
    checks++; if ({bus.stopIn, frameErr, state} !== 4'b1010) begin errors++; $display("FAIL bp_hold: got stop %b err %b state %0d, required 1 0 2", bus.stopIn, frameErr, state); end
    bus.outReady = 1;
    for (int c = 0; c < 10; c++) begin
      if (!bus.stopIn) break;
      tick();
    end
    checks++; if (bus.stopIn !== 1'b0) begin errors++; $display("FAIL bp_release: got %b, required 0", bus.stopIn); end
    push(8'hEE, 1, 1);
    enable = 0; bus.Sync = 0;
    wait_state(2'd0, 20);
    checks++; if ({frameErr, frameCount} !== {1'b0, 16'd1} || sb.size() != 0) begin errors++; $display("FAIL bp_done: got err %b count %0d left %0d, required 0 1 0", frameErr, frameCount, sb.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    enter_receive();
    for (int i = 0; i < 5; i++) begin
      bus.pushByte = 1; bus.Byte = 8'h50 + 8'(i);
      if (i < 4) sb.push_back({i == 3, 8'h50 + 8'(i)});
      tick();
    end
    bus.pushByte = 0;
    checks++; if ({frameErr, state} !== 3'b110) begin errors++; $display("FAIL ovf_err: got err %b state %0d, required 1 2", frameErr, state); end
    bus.Sync = 0; enable = 0; tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ovf_drain: got %0d, required 3", state); end
    bus.outReady = 1;
    wait_state(2'd0, 20);
    checks++; if ({frameErr, frameCount} !== {1'b1, 16'd1} || sb.size() != 0) begin errors++; $display("FAIL ovf_done: got err %b count %0d left %0d, required 1 1 0", frameErr, frameCount, sb.size()); end
  endtask

  task automatic test_max_frame();
    do_reset();
    bus.outReady = 1;
    enter_receive();
    for (int i = 0; i < MAXF - 1; i++) push(8'h60 + 8'(i), 0, 0);
    checks++; if ({frameErr, state} !== 3'b010) begin errors++; $display("FAIL max_below: got err %b state %0d, required 0 2", frameErr, state); end
    push(8'h65, 0, 1);
    checks++; if ({frameErr, state} !== 3'b111) begin errors++; $display("FAIL max_hit: got err %b state %0d, required 1 3", frameErr, state); end
    enable = 0; bus.Sync = 0;
    wait_state(2'd0, 20);
    checks++; if (frameCount !== 16'd1 || sb.size() != 0) begin errors++; $display("FAIL max_done: got count %0d left %0d, required 1 0", frameCount, sb.size()); end
  endtask

  task automatic test_sync_loss();
    do_reset();
    bus.outReady = 1;
    enter_receive();
    push(8'hA0, 0, 0);
    bus.Sync = 0;
    push(8'hA1, 0, 1);
    checks++; if ({frameErr, state} !== 3'b111) begin errors++; $display("FAIL sync_drain: got err %b state %0d, required 1 3", frameErr, state); end
    enable = 0;
    wait_state(2'd0, 20);
    checks++; if ({frameErr, frameCount} !== {1'b1, 16'd1} || sb.size() != 0) begin errors++; $display("FAIL sync_done: got err %b count %0d left %0d, required 1 1 0", frameErr, frameCount, sb.size()); end
  endtask

  task automatic test_reset_mid();
    bus.outReady = 0;
    enter_receive();
    push(8'h71, 0, 0); push(8'h72, 0, 0);
    checks++; if (bus.outValid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid %b, required 1", bus.outValid); end
    reset = 0; #1;
    checks++; if ({bus.outValid, bus.stopIn, state} !== 4'b0100) begin errors++; $display("FAIL rstmid_outs: got valid %b stop %b state %0d, required 0 1 0", bus.outValid, bus.stopIn, state); end
    checks++; if (frameCount !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d, required 0", frameCount); end
    sb.delete(); idle_inputs(); tick(); reset = 1; tick();
  endtask

  task automatic test_crc();
    logic exp_bad;
    do_reset();
    bus.outReady = 1;
    enter_receive();
    push(8'h01, 0, 0); push(8'h02, 0, 0); push(8'h1B, 1, 1);
    enable = 0; bus.Sync = 0;
    wait_state(2'd0, 20);
    checks++; if (crcErr !== 1'b0) begin errors++; $display("FAIL crc_good: got %b, required 0", crcErr); end
`ifdef COSTAS_FRAME_CRC_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    enter_receive();
    push(8'h01, 0, 0); push(8'h02, 0, 0); push(8'h1A, 1, 1);
    enable = 0; bus.Sync = 0;
    wait_state(2'd0, 20);
    checks++; if (crcErr !== exp_bad) begin errors++; $display("FAIL crc_bad: got %b, required %b", crcErr, exp_bad); end
    checks++; if (frameCount !== 16'd2 || sb.size() != 0) begin errors++; $display("FAIL crc_frames: got count %0d left %0d, required 2 0", frameCount, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_adc_forward();
    test_lock_frame();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_max_frame();
    test_sync_loss();
    test_reset_mid();
    test_crc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
